simple_tx: RTL and testbench

Packet transmitter, the stage directly upstream of the receive path. It accepts one payload over an AXI-Stream-style byte slave and stores it whole in an internal buffer, because the size byte precedes the payload on the wire. It then serialises the frame onto the byte-wide txd/txen/txer line interface that feeds the receiver's rxd/rxdv/rxer inputs. Frame on the wire: 55 55 55 7F, 12 34, size, payload, FCS.

---
 rtl/simple_tx.sv | 231 +++++++++++++++++++++++
 tb/tb_simple_tx.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simple_tx.sv
// -----------------------------------------------------------------------------
// simple_tx
// Packet transmitter. One payload is taken over a byte-wide AXI-Stream-style
// slave and buffered whole, because the size byte goes out ahead of the
// payload. The frame is then serialised onto the txd/txen/txer line:
//   55 55 55 7F | 12 34 | size | payload[0..n-1] | FCS
// FCS is the XOR of the size byte and every payload byte. After each frame
// the line is held idle for G_IFG cycles before a new packet is accepted.
//
// Ports
//   clk_in               clock
//   rst_in               synchronous reset, active-high
//   tdata_in             payload byte
//   tvalid_in            byte valid
//   tlast_in             last payload byte of packet
//   tready_out           slave ready (high only while loading/discarding)
//   inject_err_in        sampled on the tlast beat; raises txer_out over the
//                        payload bytes of that frame
//   txd_out              line data (0 while txen_out is low)
//   txen_out             line data valid
//   txer_out             line error flag
//   stat_packet_sent_cnt frames transmitted, saturating
//   stat_packet_drop_cnt packets dropped (under/oversize), saturating
// -----------------------------------------------------------------------------
module simple_tx #(
  parameter int G_MEM_SIZE = 256,
  parameter int G_IFG      = 12
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [7:0]  tdata_in,
  input  logic        tvalid_in,
  input  logic        tlast_in,
  output logic        tready_out,
  input  logic        inject_err_in,
  output logic [7:0]  txd_out,
  output logic        txen_out,
  output logic        txer_out,
  output logic [15:0] stat_packet_sent_cnt,
  output logic [15:0] stat_packet_drop_cnt
);

  localparam int C_SIZE_MIN = 8;
  // Largest payload: limited by the buffer and by the 8-bit size byte.
  localparam int C_MAX      = (G_MEM_SIZE < 255) ? G_MEM_SIZE : 255;
  localparam int C_AW       = (G_MEM_SIZE > 1) ? $clog2(G_MEM_SIZE) : 1;

  typedef enum logic [2:0] {
    S_LOAD, S_DISCARD, S_SFD, S_TYPE, S_SIZE, S_PAYLOAD, S_FCS, S_GAP
  } state_t;

  state_t      state_reg;
  logic [8:0]  cnt_reg;        // bytes stored so far in LOAD
  logic [8:0]  cnt_next;       // count including the current beat
  logic [7:0]  len_reg;        // latched payload length n
  logic [7:0]  idx_reg;        // position within SFD/TYPE/PAYLOAD/GAP
  logic [7:0]  fcs_reg;
  logic        inject_reg;
  logic        tready_reg;
  logic [7:0]  txd_reg;
  logic        txen_reg;
  logic        txer_reg;
  logic [15:0] sent_reg;
  logic [15:0] drop_reg;

  logic [7:0]      mem [G_MEM_SIZE];
  logic [7:0]      rd_data_reg;
  logic [C_AW-1:0] rd_addr;
  logic [C_AW-1:0] wr_addr;
  logic            beat;

  assign beat     = tvalid_in && tready_reg;
  assign cnt_next = cnt_reg + 9'd1;
  assign wr_addr  = C_AW'(cnt_reg);

  // The read port runs one byte ahead of the payload being driven: while in
  // PAYLOAD at position i the RAM fetches byte i+1, and in every other state
  // it holds byte 0 so it is ready on the first payload cycle.
  always_comb begin
    rd_addr = '0;
    if (state_reg == S_PAYLOAD) begin
      rd_addr = C_AW'({1'b0, idx_reg} + 9'd1);
    end
  end

  // Payload buffer: plain array, registered read, no reset.
  always_ff @(posedge clk_in) begin
    if (beat && (state_reg == S_LOAD)) begin
      mem[wr_addr] <= tdata_in;
    end
    rd_data_reg <= mem[rd_addr];
  end

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Control FSM with registered line outputs. Line outputs default to idle
  // every cycle and are only driven while a frame is in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg  <= S_LOAD;
      cnt_reg    <= '0;
      len_reg    <= '0;
      idx_reg    <= '0;
      fcs_reg    <= '0;
      inject_reg <= 1'b0;
      tready_reg <= 1'b0;
      txd_reg    <= '0;
      txen_reg   <= 1'b0;
      txer_reg   <= 1'b0;
      sent_reg   <= '0;
      drop_reg   <= '0;
    end else begin
      txd_reg  <= '0;
      txen_reg <= 1'b0;
      txer_reg <= 1'b0;
      case (state_reg)
        S_LOAD: begin
          tready_reg <= 1'b1;
          if (beat) begin
            if (tlast_in) begin
              cnt_reg <= '0;
              if (cnt_next >= 9'(C_SIZE_MIN)) begin
                len_reg    <= cnt_next[7:0];
                inject_reg <= inject_err_in;
                idx_reg    <= '0;
                tready_reg <= 1'b0;
                state_reg  <= S_SFD;
              end else begin
                drop_reg <= sat_inc(drop_reg);
              end
            end else if (cnt_next >= 9'(C_MAX)) begin
              // More bytes follow, so the packet cannot fit: drop it now
              // and swallow the rest.
              drop_reg  <= sat_inc(drop_reg);
              cnt_reg   <= '0;
              state_reg <= S_DISCARD;
            end else begin
              cnt_reg <= cnt_next;
            end
          end
        end

        S_DISCARD: begin
          tready_reg <= 1'b1;
          if (beat && tlast_in) begin
            cnt_reg   <= '0;
            state_reg <= S_LOAD;
          end
        end

        S_SFD: begin
          txen_reg <= 1'b1;
          txd_reg  <= (idx_reg == 8'd3) ? 8'h7F : 8'h55;
          if (idx_reg == 8'd3) begin
            idx_reg   <= '0;
            state_reg <= S_TYPE;
          end else begin
            idx_reg <= idx_reg + 8'd1;
          end
        end

        S_TYPE: begin
          txen_reg <= 1'b1;
          txd_reg  <= (idx_reg == 8'd0) ? 8'h12 : 8'h34;
          if (idx_reg == 8'd1) begin
            idx_reg   <= '0;
            state_reg <= S_SIZE;
          end else begin
            idx_reg <= idx_reg + 8'd1;
          end
        end

        S_SIZE: begin
          txen_reg  <= 1'b1;
          txd_reg   <= len_reg;
          fcs_reg   <= len_reg;
          idx_reg   <= '0;
          state_reg <= S_PAYLOAD;
        end

        S_PAYLOAD: begin
          txen_reg <= 1'b1;
          txer_reg <= inject_reg;
          txd_reg  <= rd_data_reg;
          fcs_reg  <= fcs_reg ^ rd_data_reg;
          if (idx_reg == len_reg - 8'd1) begin
            idx_reg   <= '0;
            state_reg <= S_FCS;
          end else begin
            idx_reg <= idx_reg + 8'd1;
          end
        end

        S_FCS: begin
          txen_reg  <= 1'b1;
          txd_reg   <= fcs_reg;
          sent_reg  <= sat_inc(sent_reg);
          idx_reg   <= '0;
          state_reg <= S_GAP;
        end

        S_GAP: begin
          // The FCS byte is still on the line during the first GAP cycle,
          // so counting to G_IFG (not G_IFG-1) gives G_IFG idle line cycles
          // before tready_out rises.
          if (idx_reg == 8'(G_IFG)) begin
            idx_reg    <= '0;
            tready_reg <= 1'b1;
            state_reg  <= S_LOAD;
          end else begin
            idx_reg <= idx_reg + 8'd1;
          end
        end

        default: begin
          state_reg <= S_LOAD;
        end
      endcase
    end
  end

  assign tready_out           = tready_reg;
  assign txd_out              = txd_reg;
  assign txen_out             = txen_reg;
  assign txer_out             = txer_reg;
  assign stat_packet_sent_cnt = sent_reg;
  assign stat_packet_drop_cnt = drop_reg;

endmodule

// File: tb/tb_simple_tx.sv
`timescale 1ns/1ps
module tb_simple_tx;

  localparam int G_MEM_SIZE = 256;
  localparam int G_IFG      = 12;
  localparam int C_MIN      = 8;
  localparam int C_MAX      = (G_MEM_SIZE < 255) ? G_MEM_SIZE : 255;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [7:0]  tdata_in = 8'd0;
  logic        tvalid_in = 1'b0;
  logic        tlast_in = 1'b0;
  logic        inject_err_in = 1'b0;
  logic        tready_out;
  logic [7:0]  txd_out;
  logic        txen_out;
  logic        txer_out;
  logic [15:0] stat_packet_sent_cnt;
  logic [15:0] stat_packet_drop_cnt;

  simple_tx #(.G_MEM_SIZE(G_MEM_SIZE), .G_IFG(G_IFG)) dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .tdata_in            (tdata_in),
    .tvalid_in           (tvalid_in),
    .tlast_in            (tlast_in),
    .tready_out          (tready_out),
    .inject_err_in       (inject_err_in),
    .txd_out             (txd_out),
    .txen_out            (txen_out),
    .txer_out            (txer_out),
    .stat_packet_sent_cnt(stat_packet_sent_cnt),
    .stat_packet_drop_cnt(stat_packet_drop_cnt)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_mis = 0;

  // ---------------- line monitor (samples on falling edge) ----------------
  int         cyc = 0;
  bit         in_frame = 1'b0;
  bit         in_gap = 1'b0;
  int         gap_cnt = 0;
  int         cur_len = 0;
  int         cur_start = 0;
  logic [8:0] cap_words[$];
  int         cap_lens[$];
  int         cap_starts[$];
  int         gaps[$];
  int         idle_bad = 0;
  int         rdy_bad = 0;

  initial begin
    forever begin
      @(negedge clk_in);
      cyc++;
      if (txen_out) begin
        if (!in_frame) begin
          in_frame  = 1'b1;
          cur_len   = 0;
          cur_start = cyc;
        end
        cap_words.push_back({txer_out, txd_out});
        cur_len++;
        if (tready_out) rdy_bad++;
      end else begin
        if (txd_out != 8'd0 || txer_out) idle_bad++;
        if (in_frame) begin
          in_frame = 1'b0;
          cap_lens.push_back(cur_len);
          cap_starts.push_back(cur_start);
          in_gap  = 1'b1;
          gap_cnt = 0;
        end
        if (in_gap) begin
          if (tready_out) begin
            gaps.push_back(gap_cnt);
            in_gap = 1'b0;
          end else begin
            gap_cnt++;
          end
        end
      end
    end
  end

  // ---------------- reference model ----------------
  logic [8:0] exp_words[$];
  int         exp_lens[$];
  int         exp_tl[$];
  int         exp_sent = 0;
  int         exp_drop = 0;
  logic [7:0] pl[$];
  int         last_cyc = 0;
  int         stall_cnt = 0;

  function automatic void check(string name, int got, int exp);
    n_vec++;
    if (got != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endfunction

  // Frame content derived straight from the wire format: preamble, type,
  // size, payload (txer = inject flag), XOR checksum over size+payload.
  task automatic model_pkt(input bit inj);
    int n;
    logic [7:0] fcs;
    n = pl.size();
    if (n < C_MIN || n > C_MAX) begin
      exp_drop++;
      return;
    end
    exp_words.push_back({1'b0, 8'h55});
    exp_words.push_back({1'b0, 8'h55});
    exp_words.push_back({1'b0, 8'h55});
    exp_words.push_back({1'b0, 8'h7F});
    exp_words.push_back({1'b0, 8'h12});
    exp_words.push_back({1'b0, 8'h34});
    fcs = 8'(n);
    exp_words.push_back({1'b0, fcs});
    foreach (pl[i]) begin
      exp_words.push_back({inj, pl[i]});
      fcs = fcs ^ pl[i];
    end
    exp_words.push_back({1'b0, fcs});
    exp_lens.push_back(n + 8);
    exp_tl.push_back(last_cyc);
    exp_sent++;
  endtask

  // ---------------- driver ----------------
  // Inputs change 1ns after the falling edge; tready_out read there is the
  // value the next rising edge will see.
  task automatic send_pkt(input bit inj, input bit holes, input bit keep);
    int i;
    int budget;
    int n;
    i = 0;
    budget = 0;
    n = pl.size();
    stall_cnt = 0;
    while (i < n) begin
      @(negedge clk_in); #1;
      budget++;
      if (budget > 4000) begin
        check("send_timeout", i, n);
        break;
      end
      if (holes && $urandom_range(0, 3) == 0) begin
        tvalid_in = 1'b0;
        tlast_in  = 1'b0;
        tdata_in  = 8'($urandom);
      end else begin
        tvalid_in     = 1'b1;
        tdata_in      = pl[i];
        tlast_in      = (i == n - 1);
        inject_err_in = (i == n - 1) ? inj : 1'($urandom);
        if (tready_out) begin
          if (i == n - 1) last_cyc = cyc;
          i++;
        end else if (i == 0) begin
          stall_cnt++;
        end
      end
    end
    if (!keep) begin
      @(negedge clk_in); #1;
      tvalid_in     = 1'b0;
      tlast_in      = 1'b0;
      inject_err_in = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    repeat (4) @(negedge clk_in);
    #2;
    while (in_frame || in_gap || !tready_out || txen_out) begin
      @(negedge clk_in); #2;
      t++;
      if (t > 2000) begin
        check("idle_timeout", t, 0);
        break;
      end
    end
  endtask

  task automatic clear_all();
    cap_words.delete(); cap_lens.delete(); cap_starts.delete(); gaps.delete();
    exp_words.delete(); exp_lens.delete(); exp_tl.delete();
    idle_bad = 0;
    rdy_bad  = 0;
  endtask

  task automatic compare_all();
    int m;
    int bad;
    int first;
    check("frame_count", cap_lens.size(), exp_lens.size());
    m = (cap_lens.size() < exp_lens.size()) ? cap_lens.size() : exp_lens.size();
    for (int k = 0; k < m; k++) begin
      check("frame_len", cap_lens[k], exp_lens[k]);
      check("tlast_to_sfd", cap_starts[k] - exp_tl[k], 2);
    end
    m = (cap_words.size() < exp_words.size()) ? cap_words.size() : exp_words.size();
    bad = 0;
    first = -1;
    for (int k = 0; k < m; k++) begin
      if (cap_words[k] !== exp_words[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    check("frame_words_bad", bad, 0);
    if (first >= 0)
      $display("  first differing word %0d: {txer,txd} got %03h want %03h",
               first, cap_words[first], exp_words[first]);
    check("ifg_count", gaps.size(), exp_lens.size());
    foreach (gaps[k]) check("ifg_len", gaps[k], G_IFG);
    check("sent_cnt", int'(stat_packet_sent_cnt), exp_sent);
    check("drop_cnt", int'(stat_packet_drop_cnt), exp_drop);
    check("idle_line_clean", idle_bad, 0);
    check("tready_low_in_frame", rdy_bad, 0);
    clear_all();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int len;
    bit inj;
    bit holes;
    int exp_txen;      // txen cycles of the resulting frame, 0 if dropped
    int exp_sent_inc;
    int exp_drop_inc;
  } vec_t;

  vec_t       tbl [12];
  logic [7:0] lit [16];

  initial begin
    int s0, d0, got, t, sc;
    int len;
    bit inj, holes;

    tbl = '{
      '{5,   1'b0, 1'b0, 0,   0, 1},
      '{8,   1'b0, 1'b1, 16,  1, 0},
      '{300, 1'b0, 1'b0, 0,   0, 1},
      '{255, 1'b0, 1'b0, 263, 1, 0},
      '{8,   1'b1, 1'b0, 16,  1, 0},
      '{8,   1'b0, 1'b0, 16,  1, 0},
      '{7,   1'b0, 1'b1, 0,   0, 1},
      '{1,   1'b1, 1'b0, 0,   0, 1},
      '{256, 1'b0, 1'b1, 0,   0, 1},
      '{254, 1'b1, 1'b1, 262, 1, 0},
      '{9,   1'b0, 1'b0, 17,  1, 0},
      '{20,  1'b1, 1'b0, 28,  1, 0}
    };
    lit = '{8'h55, 8'h55, 8'h55, 8'h7F, 8'h12, 8'h34, 8'h08, 8'h01,
            8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00};

    // ---- reset state ----
    rst_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_tready", int'(tready_out), 0);
    check("rst_txen", int'(txen_out), 0);
    check("rst_txd", int'(txd_out), 0);
    check("rst_txer", int'(txer_out), 0);
    check("rst_sent", int'(stat_packet_sent_cnt), 0);
    check("rst_drop", int'(stat_packet_drop_cnt), 0);
    #1 rst_in = 1'b0;
    @(negedge clk_in); #2;
    check("post_rst_tready", int'(tready_out), 1);
    $display("reset: tready=%0d txen=%0d", tready_out, txen_out);

    // ---- payload 01..08, literal frame ----
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'(i + 1));
    send_pkt(1'b0, 1'b0, 1'b0);
    model_pkt(1'b0);
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      got = (i < cap_words.size()) ? int'(cap_words[i]) : -1;
      check("literal_word", got, int'({1'b0, lit[i]}));
    end
    $display("pkt 01..08: txen_cycles=%0d sent=%0d", cap_lens.size() > 0 ? cap_lens[0] : 0,
             stat_packet_sent_cnt);
    compare_all();

    // ---- table-driven vectors ----
    for (int v = 0; v < 12; v++) begin
      pl.delete();
      for (int i = 0; i < tbl[v].len; i++) pl.push_back(8'($urandom));
      s0 = int'(stat_packet_sent_cnt);
      d0 = int'(stat_packet_drop_cnt);
      send_pkt(tbl[v].inj, tbl[v].holes, 1'b0);
      // One cycle after the tlast beat tready is up again only if dropped.
      check("post_tlast_tready", int'(tready_out), (tbl[v].exp_txen == 0) ? 1 : 0);
      model_pkt(tbl[v].inj);
      wait_idle();
      got = (cap_lens.size() > 0) ? cap_lens[cap_lens.size() - 1] : 0;
      check("tbl_txen_cycles", got, tbl[v].exp_txen);
      check("tbl_sent_inc", int'(stat_packet_sent_cnt) - s0, tbl[v].exp_sent_inc);
      check("tbl_drop_inc", int'(stat_packet_drop_cnt) - d0, tbl[v].exp_drop_inc);
      $display("vec %0d: len=%0d inj=%0d holes=%0d txen_cycles=%0d sent=%0d drop=%0d",
               v, tbl[v].len, tbl[v].inj, tbl[v].holes, got,
               stat_packet_sent_cnt, stat_packet_drop_cnt);
      compare_all();
    end

    // ---- back-to-back 10-byte packets, tvalid held high ----
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
    send_pkt(1'b0, 1'b0, 1'b1);
    model_pkt(1'b0);
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
    send_pkt(1'b0, 1'b0, 1'b0);
    sc = stall_cnt;
    model_pkt(1'b0);
    // Low for: the cycle before the first SFD byte, the 18-cycle frame, IFG.
    check("b2b_tready_low", sc, 1 + (10 + 8) + G_IFG);
    wait_idle();
    $display("b2b: tready_low=%0d frames=%0d sent=%0d", sc, cap_lens.size(), stat_packet_sent_cnt);
    compare_all();

    // ---- reset on the 3rd payload cycle ----
    pl.delete();
    for (int i = 0; i < 10; i++) pl.push_back(8'($urandom));
    send_pkt(1'b0, 1'b0, 1'b0);
    t = 0;
    while (!(in_frame && cur_len == 9)) begin
      @(negedge clk_in); #2;
      t++;
      if (t > 100) begin
        check("midrst_wait_timeout", t, 0);
        break;
      end
    end
    rst_in = 1'b1;
    @(negedge clk_in); #2;
    check("midrst_txen", int'(txen_out), 0);
    check("midrst_txd", int'(txd_out), 0);
    check("midrst_txer", int'(txer_out), 0);
    check("midrst_sent", int'(stat_packet_sent_cnt), 0);
    check("midrst_drop", int'(stat_packet_drop_cnt), 0);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    #2;
    got = (cap_lens.size() > 0) ? cap_lens[cap_lens.size() - 1] : 0;
    check("midrst_truncated_len", got, 9);
    $display("midrst: truncated after %0d words, sent=%0d", got, stat_packet_sent_cnt);
    clear_all();
    exp_sent = 0;
    exp_drop = 0;
    pl.delete();
    for (int i = 0; i < 8; i++) pl.push_back(8'($urandom));
    send_pkt(1'b0, 1'b0, 1'b0);
    model_pkt(1'b0);
    wait_idle();
    $display("post-reset pkt: txen_cycles=%0d", cap_lens.size() > 0 ? cap_lens[0] : 0);
    compare_all();

    // ---- randomized traffic against the model ----
    for (int r = 0; r < 16; r++) begin
      len   = ($urandom_range(0, 9) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 24);
      inj   = 1'($urandom);
      holes = 1'($urandom);
      pl.delete();
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      send_pkt(inj, holes, 1'b0);
      model_pkt(inj);
      $display("rand %0d: len=%0d inj=%0d holes=%0d", r, len, inj, holes);
    end
    wait_idle();
    compare_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
